// File: rtl/pq_autotest.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pq_autotest : built-in self test for a priority queue. The queue is      |
// | flushed, filled with LFSR keys and drained, and the drain order and the  |
// | {key,value} integrity are checked.                                       |
// | Optional first-error log enabled by macro PQ_AUTOTEST_ERRLOG_EN.         |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module pq_autotest #(
    parameter int KW        = 8,
    parameter int NUM_ITEMS = 16,
    parameter int SEED      = 1,
    parameter int ORDER_MAX = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            pq_full,
    input  logic            pq_empty,
    input  logic            pq_busy,
    input  logic [2*KW-1:0] pq_kvo,
    output logic            pq_enq,
    output logic            pq_deq,
    output logic [2*KW-1:0] pq_kvi,
    output logic            sig_idle,
    output logic            sig_flush,
    output logic            sig_fill,
    output logic            sig_drain,
    output logic            sig_done,
    output logic            pass,
    output logic [7:0]      err_count,
    output logic [7:0]      fill_count
`ifdef PQ_AUTOTEST_ERRLOG_EN
    ,
    output logic [7:0]      err_index,
    output logic [KW-1:0]   err_key
`endif
);

    typedef enum logic [4:0] {
        S_IDLE  = 5'b00001,
        S_FLUSH = 5'b00010,
        S_FILL  = 5'b00100,
        S_DRAIN = 5'b01000,
        S_DONE  = 5'b10000
    } state_t;

    localparam logic [7:0]    N_ITEMS   = 8'(NUM_ITEMS);
    localparam logic [KW-1:0] LFSR_SEED = KW'(SEED);

    state_t        state_q;
    logic [KW-1:0] lfsr_q;
    logic [KW-1:0] lfsr_d;
    logic [7:0]    err_count_q;
    logic [7:0]    err_count_d;
    logic [7:0]    fill_count_q;
    logic [7:0]    drain_cnt_q;
    logic [KW-1:0] prev_key_q;
    logic          pass_q;
`ifdef PQ_AUTOTEST_ERRLOG_EN
    logic [7:0]    err_index_q;
    logic [KW-1:0] err_key_q;
`endif

    logic [KW-1:0] head_key;
    logic [KW-1:0] head_val;
    logic          head_ok;
    logic          drain_more;
    logic          drain_fire;
    logic          underrun;
    logic          order_err;
    logic          integ_err;
    logic [1:0]    fail_inc;
    logic [8:0]    err_sum;

    assign head_key   = pq_kvo[2*KW-1:KW];
    assign head_val   = pq_kvo[KW-1:0];
    assign head_ok    = !pq_empty && !pq_busy;
    assign drain_more = (drain_cnt_q != fill_count_q);
    assign drain_fire = rst && (state_q == S_DRAIN) && head_ok && drain_more;
    assign underrun   = (state_q == S_DRAIN) && pq_empty && !pq_busy && drain_more;

    // The first drained key has no predecessor and is exempt from the order check
    assign order_err = (drain_cnt_q != 8'd0) &&
                       ((ORDER_MAX != 0) ? (head_key > prev_key_q) : (head_key < prev_key_q));
    assign integ_err = (head_key != head_val);

    always_comb begin
        fail_inc = 2'd0;
        if (drain_fire) begin
            fail_inc = {1'b0, order_err} + {1'b0, integ_err};
        end else if (underrun) begin
            fail_inc = 2'd1;
        end
    end

    assign err_sum     = {1'b0, err_count_q} + {7'd0, fail_inc};
    assign err_count_d = err_sum[8] ? 8'hFF : err_sum[7:0];

    generate
        if (KW == 16) begin : g_taps16
            assign lfsr_d = {lfsr_q[KW-2:0], lfsr_q[15] ^ lfsr_q[14] ^ lfsr_q[12] ^ lfsr_q[3]};
        end else begin : g_taps8
            assign lfsr_d = {lfsr_q[KW-2:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        end
    endgenerate

    // Strobes are held low during reset so an abandoned run cannot pop an extra entry
    assign pq_enq = rst && (state_q == S_FILL) && !pq_full && !pq_busy &&
                    (fill_count_q != N_ITEMS);
    assign pq_deq = rst && head_ok &&
                    ((state_q == S_FLUSH) || ((state_q == S_DRAIN) && drain_more));
    assign pq_kvi = {lfsr_q, lfsr_q};

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            lfsr_q       <= LFSR_SEED;
            err_count_q  <= 8'd0;
            fill_count_q <= 8'd0;
            drain_cnt_q  <= 8'd0;
            prev_key_q   <= '0;
            pass_q       <= 1'b0;
`ifdef PQ_AUTOTEST_ERRLOG_EN
            err_index_q  <= 8'd0;
            err_key_q    <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) state_q <= S_FLUSH;
                end
                S_FLUSH: begin
                    err_count_q  <= 8'd0;
                    fill_count_q <= 8'd0;
                    drain_cnt_q  <= 8'd0;
                    prev_key_q   <= '0;
                    lfsr_q       <= LFSR_SEED;
                    pass_q       <= 1'b0;
`ifdef PQ_AUTOTEST_ERRLOG_EN
                    err_index_q  <= 8'd0;
                    err_key_q    <= '0;
`endif
                    if (pq_empty && !pq_busy) state_q <= S_FILL;
                end
                S_FILL: begin
                    if (fill_count_q == N_ITEMS) begin
                        state_q <= S_DRAIN;
                    end else if (!pq_busy) begin
                        if (pq_full) begin
                            state_q <= S_DRAIN;
                        end else begin
                            lfsr_q       <= lfsr_d;
                            fill_count_q <= fill_count_q + 8'd1;
                            if (fill_count_q + 8'd1 == N_ITEMS) state_q <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    err_count_q <= err_count_d;
`ifdef PQ_AUTOTEST_ERRLOG_EN
                    if ((err_count_q == 8'd0) && (fail_inc != 2'd0)) begin
                        err_index_q <= drain_cnt_q;
                        err_key_q   <= drain_fire ? head_key : '0;
                    end
`endif
                    if (!drain_more) begin
                        state_q <= S_DONE;
                        pass_q  <= (err_count_q == 8'd0);
                    end else if (underrun) begin
                        state_q <= S_DONE;
                        pass_q  <= 1'b0;
                    end else if (drain_fire) begin
                        drain_cnt_q <= drain_cnt_q + 8'd1;
                        prev_key_q  <= head_key;
                        if (drain_cnt_q + 8'd1 == fill_count_q) begin
                            state_q <= S_DONE;
                            pass_q  <= (err_count_d == 8'd0);
                        end
                    end
                end
                S_DONE: begin
                    if (!start) begin
                        state_q <= S_IDLE;
                        pass_q  <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign sig_idle   = (state_q == S_IDLE);
    assign sig_flush  = (state_q == S_FLUSH);
    assign sig_fill   = (state_q == S_FILL);
    assign sig_drain  = (state_q == S_DRAIN);
    assign sig_done   = (state_q == S_DONE);
    assign pass       = pass_q;
    assign err_count  = err_count_q;
    assign fill_count = fill_count_q;
`ifdef PQ_AUTOTEST_ERRLOG_EN
    assign err_index  = err_index_q;
    assign err_key    = err_key_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pq_autotest.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pq_autotest : directed bench for pq_autotest with a behavioural      |
// | min-queue model that can inject swap, full, underrun and corruption.     |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_pq_autotest;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        pq_full = 1'b0;
    logic        pq_empty = 1'b1;
    logic        pq_busy = 1'b0;
    logic [15:0] pq_kvo = 16'h0;
    logic        pq_enq, pq_deq;
    logic [15:0] pq_kvi;
    logic        sig_idle, sig_flush, sig_fill, sig_drain, sig_done;
    logic        pass;
    logic [7:0]  err_count, fill_count;
`ifdef PQ_AUTOTEST_ERRLOG_EN
    logic [7:0]  err_index, err_key;
`endif

    always #5 clk = ~clk;

    pq_autotest #(.KW(8), .NUM_ITEMS(4), .SEED(1), .ORDER_MAX(0)) dut (
        .clk(clk), .rst(rst), .start(start),
        .pq_full(pq_full), .pq_empty(pq_empty), .pq_busy(pq_busy), .pq_kvo(pq_kvo),
        .pq_enq(pq_enq), .pq_deq(pq_deq), .pq_kvi(pq_kvi),
        .sig_idle(sig_idle), .sig_flush(sig_flush), .sig_fill(sig_fill),
        .sig_drain(sig_drain), .sig_done(sig_done),
        .pass(pass), .err_count(err_count), .fill_count(fill_count)
`ifdef PQ_AUTOTEST_ERRLOG_EN
        , .err_index(err_index), .err_key(err_key)
`endif
    );

    // Scenario controls, written only by the stimulus process
    int clr_gen = 0;
    bit keep_q = 1'b0;
    int preload = 0;
    bit swap_mode = 1'b0;
    bit busy_mode = 1'b0;
    int cap = 16;
    int drop_after = 0;
    int corrupt_idx = -1;

    // Model state, written only by the model process
    logic [15:0] q[$];
    int clr_seen = 0;
    int enq_n = 0, deq_n = 0, flush_deq_n = 0, viol_n = 0, drn = 0, cyc = 0;
    bit enq_seen = 1'b0;
    logic [15:0] key_log[8];

    function automatic int head_idx();
        return (swap_mode && enq_seen && drn == 0 && q.size() >= 2) ? 1 : 0;
    endfunction

    always @(posedge clk) begin
        int pos;
        logic [15:0] hv;
        if (clr_gen != clr_seen) begin
            clr_seen = clr_gen;
            if (!keep_q) q.delete();
            if (preload != 0) begin
                q.push_back(16'h0707);
                q.push_back(16'h5050);
            end
            enq_n = 0; deq_n = 0; flush_deq_n = 0; viol_n = 0; drn = 0;
            enq_seen = 1'b0;
        end
        if (pq_enq && pq_deq) viol_n++;
        if ((pq_enq || pq_deq) && pq_busy) viol_n++;
        if (pq_deq) begin
            if (q.size() > 0) q.delete(head_idx());
            deq_n++;
            if (enq_seen) drn++; else flush_deq_n++;
        end
        if (pq_enq) begin
            if (enq_n < 8) key_log[enq_n] = pq_kvi;
            enq_n++;
            enq_seen = 1'b1;
            pos = q.size();
            for (int i = q.size() - 1; i >= 0; i--)
                if (q[i][15:8] > pq_kvi[15:8]) pos = i;
            q.insert(pos, pq_kvi);
        end
        cyc++;
        hv = (q.size() > 0) ? q[head_idx()] : 16'h0;
        if (enq_seen && drn == corrupt_idx) hv[0] = ~hv[0];
        pq_kvo   <= hv;
        pq_empty <= (q.size() == 0) || (drop_after != 0 && enq_seen && drn >= drop_after);
        pq_full  <= (q.size() >= cap);
        pq_busy  <= busy_mode && cyc[0];
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic wait_done(input string nm);
        int n = 0;
        while (!sig_done && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk({nm, ".done_reached"}, int'(sig_done), 1);
    endtask

    typedef struct {
        string name;
        int    preload;
        bit    swap;
        int    cap;
        int    drop;
        int    corrupt;
        bit    busy;
        int    x_enq, x_deq, x_flush, x_fill, x_err;
        bit    x_pass;
        int    x_eidx, x_ekey;
    } vec_t;

    vec_t vt[8];
    logic [7:0] exp_key[4];

    initial begin
        int n;
        exp_key = '{8'h01, 8'h02, 8'h04, 8'h08};
        //        name      pre swap  cap drop cor busy  enq deq fl fill err pass  eidx ekey
        vt[0] = '{"normal",  0, 1'b0, 16, 0,  -1, 1'b0, 4,  4,  0, 4,  0,  1'b1, 0, 0};
        vt[1] = '{"swap",    0, 1'b1, 16, 0,  -1, 1'b0, 4,  4,  0, 4,  1,  1'b0, 1, 1};
        vt[2] = '{"full3",   0, 1'b0, 3,  0,  -1, 1'b0, 3,  3,  0, 3,  0,  1'b1, 0, 0};
        vt[3] = '{"preload", 2, 1'b0, 16, 0,  -1, 1'b0, 4,  6,  2, 4,  0,  1'b1, 0, 0};
        vt[4] = '{"underrun",0, 1'b0, 16, 2,  -1, 1'b0, 4,  2,  0, 4,  1,  1'b0, 2, 0};
        vt[5] = '{"corrupt", 0, 1'b0, 16, 0,   2, 1'b0, 4,  4,  0, 4,  1,  1'b0, 2, 4};
        vt[6] = '{"busy",    0, 1'b0, 16, 0,  -1, 1'b1, 4,  4,  0, 4,  0,  1'b1, 0, 0};
        vt[7] = '{"double",  0, 1'b1, 16, 0,   1, 1'b0, 4,  4,  0, 4,  2,  1'b0, 1, 1};

        repeat (3) @(negedge clk);
        chk("reset.state", int'({sig_idle, sig_flush, sig_fill, sig_drain, sig_done}), 16);
        chk("reset.strobes", int'({pq_enq, pq_deq}), 0);
        chk("reset.err_count", int'(err_count), 0);
        chk("reset.fill_count", int'(fill_count), 0);
        chk("reset.pass", int'(pass), 0);
        chk("reset.kvi_seed", int'(pq_kvi), 16'h0101);
        rst = 1'b1;

        for (int v = 0; v < 8; v++) begin
            @(negedge clk);
            keep_q = 1'b0; preload = vt[v].preload; swap_mode = vt[v].swap;
            busy_mode = vt[v].busy; cap = vt[v].cap; drop_after = vt[v].drop;
            corrupt_idx = vt[v].corrupt;
            clr_gen++;
            repeat (2) @(negedge clk);
            start = 1'b1;
            wait_done(vt[v].name);
            chk({vt[v].name, ".enq"}, enq_n, vt[v].x_enq);
            chk({vt[v].name, ".deq"}, deq_n, vt[v].x_deq);
            chk({vt[v].name, ".flush_deq"}, flush_deq_n, vt[v].x_flush);
            chk({vt[v].name, ".fill_count"}, int'(fill_count), vt[v].x_fill);
            chk({vt[v].name, ".err_count"}, int'(err_count), vt[v].x_err);
            chk({vt[v].name, ".pass"}, int'(pass), int'(vt[v].x_pass));
            chk({vt[v].name, ".strobe_rules"}, viol_n, 0);
            for (int i = 0; i < vt[v].x_fill; i++)
                chk($sformatf("%s.key%0d", vt[v].name, i), int'(key_log[i]),
                    int'({exp_key[i], exp_key[i]}));
`ifdef PQ_AUTOTEST_ERRLOG_EN
            chk({vt[v].name, ".err_index"}, int'(err_index), vt[v].x_eidx);
            chk({vt[v].name, ".err_key"}, int'(err_key), vt[v].x_ekey);
`endif
            repeat (3) @(negedge clk);
            chk({vt[v].name, ".held_in_done"}, int'(sig_done), 1);
            start = 1'b0;
            @(negedge clk);
            chk({vt[v].name, ".back_to_idle"}, int'(sig_idle), 1);
        end

        // Reset in the middle of DRAIN, then a new run must flush the residue
        keep_q = 1'b0; preload = 0; swap_mode = 1'b0; busy_mode = 1'b0;
        cap = 16; drop_after = 0; corrupt_idx = -1;
        clr_gen++;
        repeat (2) @(negedge clk);
        start = 1'b1;
        n = 0;
        while (!(sig_drain && deq_n >= 1) && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("midrst.reach_drain", int'(sig_drain), 1);
        rst = 1'b0;
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("midrst.state", int'({sig_idle, sig_flush, sig_fill, sig_drain, sig_done}), 16);
        chk("midrst.strobes", int'({pq_enq, pq_deq}), 0);
        chk("midrst.err_count", int'(err_count), 0);
        chk("midrst.fill_count", int'(fill_count), 0);
        chk("midrst.pass", int'(pass), 0);
        chk("midrst.deq_before", deq_n, 1);
`ifdef PQ_AUTOTEST_ERRLOG_EN
        chk("midrst.err_index", int'(err_index), 0);
`endif
        keep_q = 1'b1;
        clr_gen++;
        repeat (2) @(negedge clk);
        start = 1'b1;
        wait_done("rerun");
        chk("rerun.flush_deq", flush_deq_n, 3);
        chk("rerun.enq", enq_n, 4);
        chk("rerun.fill_count", int'(fill_count), 4);
        chk("rerun.err_count", int'(err_count), 0);
        chk("rerun.pass", int'(pass), 1);
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("rerun.idle", int'(sig_idle), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
